// File: rtl/atm_multi_account_ctrl.sv
// ATM session controller for NUM_ACCOUNTS accounts: PIN retries with card retention,
// inactivity timeout, per-session withdrawal limit and deposit overflow protection.
module atm_multi_account_ctrl #(
  parameter int                            NUM_ACCOUNTS   = 4,
  parameter int                            BAL_W          = 32,
  parameter int                            AMT_W          = 20,
  parameter int                            PIN_W          = 4,
  parameter logic [NUM_ACCOUNTS*PIN_W-1:0] PIN_TABLE      = 16'h321A,
  parameter longint                        INIT_BALANCE   = 1000,
  parameter int                            MAX_TRIES      = 3,
  parameter int                            WD_LIMIT       = 500,
  parameter int                            TIMEOUT_CYCLES = 1000,
  localparam int                           ACC_W          = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic [ACC_W-1:0] account_id,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [AMT_W-1:0] amount,
  input  logic             eject_card,
  output logic             session_active,
  output logic             pin_ok,
  output logic             op_done,
  output logic             op_error,
  output logic [2:0]       err_code,
  output logic [BAL_W-1:0] balance,
  output logic             card_retained,
  output logic             timeout_flag
);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PIN, S_MENU, S_EXEC, S_EJECT, S_RETAIN} state_e;

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acct_q, acct_d;
  logic [TRY_W-1:0]        tries_q, tries_d;
  logic [BAL_W-1:0]        swd_q, swd_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [1:0]              op_q, op_d;
  logic [AMT_W-1:0]        amt_q, amt_d;
  logic [BAL_W-1:0]        bal_q [NUM_ACCOUNTS];
  logic [BAL_W-1:0]        bal_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;
  logic [2:0]              err_q, err_d;
  logic                    done_q, done_d, error_q, error_d, tflag_q, tflag_d;
  logic                    sess_q, sess_d, ret_q, ret_d;
  logic [BAL_W-1:0]        bal_o_q, bal_o_d;

  logic [PIN_W-1:0] pin_tab [NUM_ACCOUNTS];
  for (genvar k = 0; k < NUM_ACCOUNTS; k++) begin : g_pin
    assign pin_tab[k] = PIN_TABLE[k*PIN_W +: PIN_W];
  end

  logic             acct_bad, tmr_hit;
  logic [BAL_W-1:0] cur_bal, amt_b, exec_bal;
  logic [BAL_W:0]   dep_sum, wd_sum;
  logic [2:0]       exec_err;

  assign acct_bad = 32'(account_id) >= 32'(NUM_ACCOUNTS);
  assign tmr_hit  = tmr_q == TMR_W'(TIMEOUT_CYCLES - 1);
  assign cur_bal  = bal_q[acct_q];
  assign amt_b    = BAL_W'(amt_q);
  assign dep_sum  = {1'b0, cur_bal} + {1'b0, amt_b};
  assign wd_sum   = {1'b0, swd_q} + {1'b0, amt_b};

  // Error checks in priority order; exec_bal is the balance to commit when exec_err is 0.
  always_comb begin
    exec_err = 3'd0;
    exec_bal = cur_bal;
    case (op_q)
      2'b01: begin
        if (amt_q == '0)      exec_err = 3'd1;
        else if (dep_sum[BAL_W]) exec_err = 3'd4;
        else                  exec_bal = dep_sum[BAL_W-1:0];
      end
      2'b10: begin
        if (amt_q == '0)                          exec_err = 3'd1;
        else if (amt_b > cur_bal)                 exec_err = 3'd2;
        else if (wd_sum > (BAL_W+1)'(WD_LIMIT))   exec_err = 3'd3;
        else                                      exec_bal = cur_bal - amt_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acct_d  = acct_q;
    tries_d = tries_q;
    swd_d   = swd_q;
    tmr_d   = tmr_q;
    op_d    = op_q;
    amt_d   = amt_q;
    bal_d   = bal_q;
    lock_d  = lock_q;
    err_d   = err_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    tflag_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (card_in) begin
        acct_d  = account_id;
        tries_d = '0;
        swd_d   = '0;
        tmr_d   = '0;
        if (acct_bad || lock_q[account_id]) begin
          state_d = S_EJECT;
          error_d = 1'b1;
          err_d   = 3'd5;
        end else begin
          state_d = S_PIN;
        end
      end
      S_PIN: begin
        if (!card_in)        state_d = S_IDLE;
        else if (eject_card) state_d = S_EJECT;
        else if (tmr_hit) begin
          state_d = S_EJECT;
          tflag_d = 1'b1;
        end else if (pin_valid) begin
          tmr_d = '0;
          if (pin == pin_tab[acct_q]) begin
            state_d = S_MENU;
          end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
            lock_d[acct_q] = 1'b1;
            state_d        = S_RETAIN;
          end else begin
            tries_d = tries_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_MENU: begin
        if (!card_in)        state_d = S_IDLE;
        else if (eject_card) state_d = S_EJECT;
        else if (tmr_hit) begin
          state_d = S_EJECT;
          tflag_d = 1'b1;
        end else if (op_valid) begin
          tmr_d = '0;
          if (op_code == 2'b11) begin
            state_d = S_EJECT;
          end else begin
            op_d    = op_code;
            amt_d   = amount;
            state_d = S_EXEC;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (!card_in)        state_d = S_IDLE;
        else if (eject_card) state_d = S_EJECT;
        else begin
          state_d = S_MENU;
          tmr_d   = '0;
          if (exec_err != 3'd0) begin
            error_d = 1'b1;
            err_d   = exec_err;
          end else begin
            done_d         = 1'b1;
            err_d          = 3'd0;
            bal_d[acct_q]  = exec_bal;
            if (op_q == 2'b10) swd_d = swd_q + amt_b;
          end
        end
      end
      S_EJECT, S_RETAIN: if (!card_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Session-level outputs follow the next state so they change on the same edge.
    sess_d  = (state_d == S_MENU) || (state_d == S_EXEC);
    ret_d   = state_d == S_RETAIN;
    bal_o_d = sess_d ? bal_d[acct_d] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      acct_q  <= '0;
      tries_q <= '0;
      swd_q   <= '0;
      tmr_q   <= '0;
      op_q    <= '0;
      amt_q   <= '0;
      for (int k = 0; k < NUM_ACCOUNTS; k++) bal_q[k] <= BAL_W'(INIT_BALANCE);
      lock_q  <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      tflag_q <= 1'b0;
      sess_q  <= 1'b0;
      ret_q   <= 1'b0;
      bal_o_q <= '0;
    end else begin
      state_q <= state_d;
      acct_q  <= acct_d;
      tries_q <= tries_d;
      swd_q   <= swd_d;
      tmr_q   <= tmr_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      bal_q   <= bal_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      done_q  <= done_d;
      error_q <= error_d;
      tflag_q <= tflag_d;
      sess_q  <= sess_d;
      ret_q   <= ret_d;
      bal_o_q <= bal_o_d;
    end
  end

  assign session_active = sess_q;
  assign pin_ok         = sess_q;
  assign op_done        = done_q;
  assign op_error       = error_q;
  assign err_code       = err_q;
  assign balance        = bal_o_q;
  assign card_retained  = ret_q;
  assign timeout_flag   = tflag_q;
endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Scoreboard bench: directed plan plus random sessions against an account-level reference model.
module tb_atm_multi_account_ctrl;
  typedef struct { bit err; int code; longint bal; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance (default sizes, short timeout)
  logic        card0, pv0, ov0, ej0;
  logic [1:0]  acc0, oc0;
  logic [3:0]  pin0;
  logic [19:0] amt0;
  logic        s_act, p_ok, o_done, o_err, retained, tflag;
  logic [2:0]  e_code;
  logic [31:0] bal0;

  // narrow-balance instance for overflow boundaries
  logic        card1, pv1, ov1, ej1;
  logic [1:0]  acc1, oc1;
  logic [3:0]  pin1;
  logic [11:0] amt1;
  logic        s_act1, p_ok1, o_done1, o_err1, retained1, tflag1;
  logic [2:0]  e_code1;
  logic [11:0] bal1;

  atm_multi_account_ctrl #(.TIMEOUT_CYCLES(16)) d0 (
    .clk(clk), .reset(rst_n), .card_in(card0), .account_id(acc0), .pin(pin0),
    .pin_valid(pv0), .op_valid(ov0), .op_code(oc0), .amount(amt0), .eject_card(ej0),
    .session_active(s_act), .pin_ok(p_ok), .op_done(o_done), .op_error(o_err),
    .err_code(e_code), .balance(bal0), .card_retained(retained), .timeout_flag(tflag));

  atm_multi_account_ctrl #(.BAL_W(12), .AMT_W(12), .INIT_BALANCE(4000), .TIMEOUT_CYCLES(16)) d1 (
    .clk(clk), .reset(rst_n), .card_in(card1), .account_id(acc1), .pin(pin1),
    .pin_valid(pv1), .op_valid(ov1), .op_code(oc1), .amount(amt1), .eject_card(ej1),
    .session_active(s_act1), .pin_ok(p_ok1), .op_done(o_done1), .op_error(o_err1),
    .err_code(e_code1), .balance(bal1), .card_retained(retained1), .timeout_flag(tflag1));

  int checks = 0, failures = 0;
  exp_t q0[$], q1[$];

  // reference model state
  longint mb[4];
  bit     ml[4];
  int     cur, mtries;
  longint mswd;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pin_of(int k);
    logic [15:0] t;
    t = 16'h321A;
    return t[k*4 +: 4];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin mb[k] = 1000; ml[k] = 0; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // monitors: pop an expectation whenever a DUT reports a result
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && (o_done || o_err)) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp0: got done=%0d err=%0d code=%0d expected no response", o_done, o_err, e_code);
      end else begin
        e = q0.pop_front();
        chk("resp0_is_error", o_err, e.err);
        chk("resp0_one_hot", o_done ^ o_err, 1);
        chk("resp0_err_code", e_code, e.code);
        chk("resp0_balance", bal0, e.bal);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && (o_done1 || o_err1)) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp1: got done=%0d err=%0d code=%0d expected no response", o_done1, o_err1, e_code1);
      end else begin
        e = q1.pop_front();
        chk("resp1_is_error", o_err1, e.err);
        chk("resp1_err_code", e_code1, e.code);
        chk("resp1_balance", bal1, e.bal);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic insert(int a);
    cur = a; mtries = 0; mswd = 0;
    acc0 = 2'(a); card0 = 1'b1;
    if (ml[a]) q0.push_back('{1'b1, 5, 0});
    tick();
    chk("inactive_after_insert", s_act, 0);
  endtask

  task automatic remove();
    card0 = 1'b0;
    tick(); tick();
    chk("inactive_after_remove", s_act, 0);
    chk("balance_zero_idle", bal0, 0);
  endtask

  // res: 0 accepted, 1 wrong, 2 card retained
  task automatic enter_pin(logic [3:0] p, output int res);
    pin0 = p; pv0 = 1'b1;
    tick();
    pv0 = 1'b0;
    if (p == pin_of(cur)) begin
      chk("pin_ok", p_ok, 1);
      chk("balance_on_login", bal0, mb[cur]);
      res = 0;
    end else begin
      mtries++;
      if (mtries == 3) begin
        ml[cur] = 1;
        chk("card_retained", retained, 1);
        chk("inactive_retained", s_act, 0);
        res = 2;
      end else begin
        chk("pin_rejected", p_ok, 0);
        res = 1;
      end
    end
  endtask

  task automatic do_op(int code, longint amt);
    exp_t e;
    e.err = 0; e.code = 0;
    if (code != 0) begin
      if (amt == 0) begin e.err = 1; e.code = 1; end
      else if (code == 2) begin
        if (amt > mb[cur])              begin e.err = 1; e.code = 2; end
        else if (mswd + amt > 500)      begin e.err = 1; e.code = 3; end
        else begin mb[cur] -= amt; mswd += amt; end
      end else begin
        if (mb[cur] + amt > 64'hFFFF_FFFF) begin e.err = 1; e.code = 4; end
        else mb[cur] += amt;
      end
    end
    e.bal = mb[cur];
    q0.push_back(e);
    oc0 = 2'(code); amt0 = 20'(amt); ov0 = 1'b1;
    tick();
    ov0 = 1'b0;
    chk("no_early_resp", o_done | o_err, 0);
    tick();
    chk("resp_present", o_done | o_err, 1);
    @(negedge clk); #1;
    chk("resp_consumed", q0.size(), 0);
  endtask

  task automatic op1(int code, int amt, bit err, int ecode, longint ebal);
    q1.push_back('{err, ecode, ebal});
    oc1 = 2'(code); amt1 = 12'(amt); ov1 = 1'b1;
    tick();
    ov1 = 1'b0;
    tick();
    @(negedge clk); #1;
    chk("resp1_consumed", q1.size(), 0);
  endtask

  initial begin
    int res, n, r, nops, a, code;
    longint amt;
    logic [3:0] p;
    card0 = 0; pv0 = 0; ov0 = 0; ej0 = 0; acc0 = 0; oc0 = 0; pin0 = 0; amt0 = 0;
    card1 = 0; pv1 = 0; ov1 = 0; ej1 = 0; acc1 = 0; oc1 = 0; pin1 = 0; amt1 = 0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_session_active", s_act, 0);
    chk("rst_op_done", o_done, 0);
    chk("rst_err_code", e_code, 0);
    chk("rst_balance", bal0, 0);
    chk("rst_retained", retained, 0);
    chk("rst_timeout", tflag, 0);
    rst_n = 1'b1;
    tick();

    // account 0: query, deposit, logout
    insert(0);
    enter_pin(4'hA, res);
    do_op(0, 0);
    do_op(1, 250);
    oc0 = 2'b11; ov0 = 1'b1; tick(); ov0 = 1'b0;
    chk("logout_ends_session", s_act, 0);
    remove();

    // account 1: withdraw, session limit, zero amount
    insert(1);
    enter_pin(pin_of(1), res);
    do_op(2, 300);
    do_op(2, 300);
    do_op(2, 0);
    remove();

    // account 2: three wrong PINs then rejected on reinsertion
    insert(2);
    for (int i = 0; i < 3; i++) enter_pin(pin_of(2) ^ 4'h5, res);
    remove();
    chk("retained_cleared", retained, 0);
    insert(2);
    tick();
    remove();

    // inactivity timeout
    insert(3);
    enter_pin(pin_of(3), res);
    n = 0;
    while (!tflag && n < 40) begin tick(); n++; end
    chk("timeout_seen", tflag, 1);
    chk("timeout_window", (n >= 16 && n <= 17), 1);
    chk("timeout_inactive", s_act, 0);
    tick();
    chk("timeout_pulse_one_cycle", tflag, 0);
    remove();

    // eject together with op_valid in MENU, and eject while in EXEC
    insert(3);
    enter_pin(pin_of(3), res);
    oc0 = 2'b01; amt0 = 20'd50; ov0 = 1'b1; ej0 = 1'b1;
    tick();
    ov0 = 1'b0; ej0 = 1'b0;
    chk("eject_beats_op", s_act, 0);
    tick(); tick();
    remove();
    insert(0);
    enter_pin(4'hA, res);
    oc0 = 2'b01; amt0 = 20'd10; ov0 = 1'b1;
    tick();
    ov0 = 1'b0; ej0 = 1'b1;
    tick();
    ej0 = 1'b0;
    chk("eject_in_exec", s_act, 0);
    tick(); tick();
    remove();

    // random sessions
    for (int s = 0; s < 30; s++) begin
      a = $urandom_range(0, 3);
      insert(a);
      if (ml[a]) begin tick(); remove(); continue; end
      res = 1;
      while (res == 1) begin
        p = pin_of(a);
        if ($urandom_range(0, 3) == 0) p = p ^ 4'($urandom_range(1, 15));
        enter_pin(p, res);
        repeat ($urandom_range(0, 2)) tick();
      end
      if (res == 2) begin remove(); continue; end
      nops = $urandom_range(1, 6);
      for (int i = 0; i < nops; i++) begin
        code = $urandom_range(0, 2);
        r = $urandom_range(0, 7);
        amt = (r == 0) ? 0 : (r == 1) ? longint'($urandom_range(1000, 3000)) : longint'($urandom_range(1, 300));
        do_op(code, amt);
        repeat ($urandom_range(0, 2)) tick();
      end
      r = $urandom_range(0, 2);
      if (r == 0) begin oc0 = 2'b11; ov0 = 1'b1; tick(); ov0 = 1'b0; end
      else if (r == 1) begin ej0 = 1'b1; tick(); ej0 = 1'b0; end
      remove();
    end

    // asynchronous reset while an op sits in EXEC
    insert(0);
    enter_pin(pin_of(0), res);
    oc0 = 2'b01; amt0 = 20'd5; ov0 = 1'b1;
    tick();
    ov0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_session", s_act, 0);
    chk("arst_pin_ok", p_ok, 0);
    chk("arst_done", o_done, 0);
    chk("arst_error", o_err, 0);
    chk("arst_err_code", e_code, 0);
    chk("arst_balance", bal0, 0);
    chk("arst_retained", retained, 0);
    chk("arst_timeout", tflag, 0);
    card0 = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    insert(0);
    enter_pin(4'hA, res);
    do_op(0, 0);
    remove();

    // 12-bit balance instance: insufficient funds and overflow boundaries
    card1 = 1'b1; acc1 = 2'd0;
    tick();
    pin1 = 4'hA; pv1 = 1'b1;
    tick();
    pv1 = 1'b0;
    chk("d1_pin_ok", p_ok1, 1);
    chk("d1_login_balance", bal1, 4000);
    op1(2, 4001, 1, 2, 4000);
    op1(1, 100, 1, 4, 4000);
    op1(1, 95, 0, 0, 4095);
    op1(1, 1, 1, 4, 4095);
    card1 = 1'b0;
    tick(); tick();
    chk("d1_inactive", s_act1, 0);

    repeat (5) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/atm_multi_account_ctrl.md
# atm_multi_account_ctrl

Parametrised next-generation ATM session controller. It serves NUM_ACCOUNTS accounts and adds PIN retry counting with card retention, a session inactivity timeout, a per-session withdrawal limit, and deposit-overflow protection. All state lives in one clock domain. It sits between the card/keypad front end and the display/cash-dispense logic.

## Interface
- NUM_ACCOUNTS, 4: number of accounts; ACC_W = max(1, $clog2(NUM_ACCOUNTS))
- BAL_W, 32: balance width
- AMT_W, 20: transaction amount width (AMT_W ≤ BAL_W)
- PIN_W, 4: PIN width
- PIN_TABLE, 16'h321A: NUM_ACCOUNTS*PIN_W bits; PIN of account k = PIN_TABLE[k*PIN_W +: PIN_W]
- INIT_BALANCE, 1000: every balance after reset
- MAX_TRIES, 3: wrong PINs before the card is retained
- WD_LIMIT, 500: maximum cumulative withdrawal per session
- TIMEOUT_CYCLES, 1000: inactivity cycles before forced eject

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- card_in  in  1  card present (level)
- account_id  in  ACC_W  account on the card; sampled on insertion
- pin  in  PIN_W  entered PIN
- pin_valid  in  1  one-cycle strobe; pin is valid
- op_valid  in  1  one-cycle strobe; op_code/amount are valid
- op_code  in  2  00 balance, 01 deposit, 10 withdraw, 11 logout
- amount  in  AMT_W  transaction amount
- eject_card  in  1  user cancel
- session_active  out  1  high in MENU/EXEC
- pin_ok  out  1  high while authenticated (MENU/EXEC)
- op_done  out  1  one-cycle pulse; operation committed
- op_error  out  1  one-cycle pulse; operation rejected
- err_code  out  3  0 none, 1 zero amount, 2 insufficient, 3 limit, 4 overflow, 5 bad account/locked
- balance  out  BAL_W  current account balance while session_active, else 0
- card_retained  out  1  high in RETAIN
- timeout_flag  out  1  one-cycle pulse on inactivity timeout

## Operation
- States: IDLE, PIN_WAIT, MENU, EXEC, EJECT, RETAIN.
- IDLE, card_in=1:
  - Latch account_id, clear tries and session_wd.
  - Go to PIN_WAIT.
  - If account_id ≥ NUM_ACCOUNTS or the account is locked: go to EJECT instead, pulse op_error, err_code=5.
- PIN_WAIT, pin_valid:
  - pin matches: go to MENU.
  - pin does not match: tries+1. When tries reaches MAX_TRIES, set the lock bit for the account and go to RETAIN.
- MENU, op_valid: latch op_code/amount and go to EXEC. Logout (11) goes directly to EJECT with no op_done.
- EXEC: evaluate and return to MENU. Checks in priority order:
  - Deposit/withdraw with amount=0 → err 1.
  - Withdraw with amount > balance → err 2.
  - Withdraw with session_wd + amount > WD_LIMIT → err 3.
  - Deposit with balance + amount > 2^BAL_W−1 → err 4.
  - Otherwise commit the balance update, add withdraw amounts to session_wd, pulse op_done, err_code=0.
  - Balance query (00) always pulses op_done.
- On error: balance and session_wd unchanged; pulse op_error; err_code holds until the next op_done/op_error.
- eject_card in PIN_WAIT/MENU/EXEC → EJECT. An op latched in EXEC is discarded.
- card_in=0 in PIN_WAIT/MENU/EXEC → IDLE. Pending op discarded.
- EJECT → IDLE once card_in=0.
- RETAIN → IDLE once card_in=0 (card removed by service). Lock bits clear only on reset.
- Timeout counter:
  - Cleared on entering PIN_WAIT/MENU and on each accepted pin_valid/op_valid.
  - Counts in PIN_WAIT/MENU.
  - Reaching TIMEOUT_CYCLES → EJECT plus timeout_flag pulse.
- Simultaneous events in MENU, highest priority first: card_in=0 > eject_card > timeout > op_valid.
- pin_valid outside PIN_WAIT and op_valid outside MENU are ignored.

## Timing
- Reset: state=IDLE, all balances=INIT_BALANCE, all lock bits=0, all counters=0, all outputs=0.
- Reset asserted mid-operation: any uncommitted op is lost; balances return to INIT_BALANCE.
- All outputs are registered.
- pin_valid sampled at edge E → pin_ok high after E.
- op_valid sampled at edge E → EXEC after E → op_done/op_error and the updated balance visible after edge E+1. Latency 2 cycles.
- MENU accepts the next op_valid one cycle after the pulse, i.e. back-to-back ops every 2 cycles.
- timeout_flag asserts after the edge where the count equals TIMEOUT_CYCLES.

## Test plan
- Defaults, TIMEOUT_CYCLES=16. Insert card acct 0, pin=4'hA, query → op_done, balance=1000. Deposit 250 → balance=1250.
- Acct 1, withdraw 300 → balance 700. Withdraw 300 → op_error, err_code=3, balance 700. Withdraw 0 → err_code=1.
- Acct 2, wrong PIN ×3 → card_retained=1. card_in=0, reinsert acct 2 → op_error, err_code=5, EJECT.
- BAL_W=12, INIT_BALANCE=4000: deposit 100 → err_code=4, balance 4000. Withdraw 4001 → err_code=2.
- Authenticated, idle 16 cycles → timeout_flag pulse, session_active=0. eject_card together with op_valid → EJECT, no op_done.
- reset low while in EXEC → all outputs 0 asynchronously; after release, balance query shows 1000.
